// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer
// Emits the core's 34-bit instruction word plus latched sideband config for one
// full conv pass: per kernel position it fetches weights into L0, loads them into
// the array, lets them settle, fetches and executes NIJ activations, then drains
// NIJ psums from the OFIFO into psum SRAM (accumulating from the second kij on).
// Every output is registered: the word visible in a cycle was decided at the edge
// that opened it, from the state and inputs sampled there.
module core_inst_sequencer #(
    parameter int ROW = 2,
    parameter int COL = 2,
    parameter int NIJ = 16,
    parameter int KIJ = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] w_base,
    input  logic [10:0] x_base,
    input  logic [10:0] p_base,
    input  logic        mode_in,
    input  logic        sel_in,
    input  logic        relu_in,
    input  logic [1:0]  tile_in,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        mode,
    output logic        sel,
    output logic        relu,
    output logic [1:0]  tile,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] ROW_C    = CNT_W'(ROW);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL - 1);
    localparam logic [CNT_W-1:0] DRN_LAST = CNT_W'(ROW + COL - 1);
    localparam logic [CNT_W-1:0] NIJ_C    = CNT_W'(NIJ);
    localparam logic [CNT_W-1:0] NIJ_LAST = CNT_W'(NIJ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       KIJ_LAST = 4'(KIJ - 1);
    localparam logic [10:0]      ROW_A    = 11'(ROW);
    // Both SRAMs disabled and not writing, no array/L0/OFIFO activity
    localparam logic [33:0]      IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WRD,
        S_WLD,
        S_WDRN,
        S_XRD,
        S_EXE,
        S_OWAIT,
        S_ORD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       k_q, k_d;
    logic [10:0]      wb_q, wb_d, xb_q, xb_d, pb_q, pb_d;
    logic             mode_q, mode_d, sel_q, sel_d, relu_q, relu_d;
    logic [1:0]       tile_q, tile_d;
    logic [33:0]      inst_q, inst_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             ord_rd;
    logic             acc, cen_p, wen_p, cen_x, ofifo_rd, l0_rd, l0_wr, exec, load;
    logic [10:0]      a_p, a_x;

    // Next-state sequencing, then the word for the cycle being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        wb_d    = wb_q;
        xb_d    = xb_q;
        pb_d    = pb_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        relu_d  = relu_q;
        tile_d  = tile_q;
        ord_rd  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRD;
                    cnt_d   = '0;
                    k_d     = '0;
                    wb_d    = w_base;
                    xb_d    = x_base;
                    pb_d    = p_base;
                    mode_d  = mode_in;
                    sel_d   = sel_in;
                    relu_d  = relu_in;
                    tile_d  = tile_in;
                end
            end
            S_WRD: begin
                if (cnt_q == ROW_C) begin
                    state_d = S_WLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WLD: begin
                if (cnt_q == COL_LAST) begin
                    state_d = S_WDRN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WDRN: begin
                if (cnt_q == DRN_LAST) begin
                    state_d = S_XRD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_XRD: begin
                if (cnt_q == NIJ_C) begin
                    state_d = S_EXE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_EXE: begin
                if (cnt_q == NIJ_LAST) begin
                    state_d = S_OWAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_OWAIT: begin
                // valid seen here means the first drain cycle already reads
                if (ofifo_valid) begin
                    state_d = S_ORD;
                    ord_rd  = 1'b1;
                    cnt_d   = CNT_ONE;
                end
            end
            S_ORD: begin
                // cnt_q counts psums already drained; a low valid pauses without skipping
                if (cnt_q == NIJ_C) begin
                    cnt_d = '0;
                    if (k_q == KIJ_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRD;
                        k_d     = k_q + 4'd1;
                    end
                end else if (ofifo_valid) begin
                    ord_rd = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        acc      = 1'b0;
        cen_p    = 1'b1;
        wen_p    = 1'b1;
        a_p      = '0;
        cen_x    = 1'b1;
        a_x      = '0;
        ofifo_rd = 1'b0;
        l0_rd    = 1'b0;
        l0_wr    = 1'b0;
        exec     = 1'b0;
        load     = 1'b0;

        case (state_d)
            S_WRD: begin
                // L0 write trails the xmem read by one cycle of SRAM latency
                l0_wr = (cnt_d != '0);
                if (cnt_d < ROW_C) begin
                    cen_x = 1'b0;
                    a_x   = wb_d + 11'(k_d) * ROW_A + cnt_d[10:0];
                end
            end
            S_WLD: begin
                l0_rd = 1'b1;
                load  = 1'b1;
            end
            S_XRD: begin
                l0_wr = (cnt_d != '0);
                if (cnt_d < NIJ_C) begin
                    cen_x = 1'b0;
                    a_x   = xb_d + cnt_d[10:0];
                end
            end
            S_EXE: begin
                l0_rd = 1'b1;
                exec  = 1'b1;
            end
            default: begin
            end
        endcase

        if (ord_rd) begin
            acc      = (k_q != 4'd0);
            cen_p    = 1'b0;
            wen_p    = 1'b0;
            a_p      = pb_q + cnt_q[10:0];
            ofifo_rd = 1'b1;
        end

        inst_d = {acc, cen_p, wen_p, a_p, cen_x, 1'b1, a_x,
                  ofifo_rd, 2'b00, l0_rd, l0_wr, exec, load};
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Control state and registered outputs; reset aborts a pass immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            sel_q   <= 1'b0;
            relu_q  <= 1'b0;
            tile_q  <= 2'b00;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            relu_q  <= relu_d;
            tile_q  <= tile_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Base addresses are reloaded on every accepted start, so they need no reset
    always_ff @(posedge clk) begin
        wb_q <= wb_d;
        xb_q <= xb_d;
        pb_q <= pb_d;
    end

    assign inst    = inst_q;
    assign mode    = mode_q;
    assign sel     = sel_q;
    assign relu    = relu_q;
    assign tile    = tile_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign kij_idx = k_q;

endmodule
